// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data memory / load-store path: funct3 codes,
// controller state encoding and the store byte-lane mask helper.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Byte lanes touched by an access of the given size (funct3[1:0]) at a lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Picks the addressed byte/halfword out of a 32-bit word and sign- or
// zero-extends it according to the load funct3.
module lsu_load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    data_c = 32'h0;
    case (funct3)
      F3_B:    data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_c = {{16{half_sel[15]}}, half_sel};
      F3_W:    data_c = word;
      F3_BU:   data_c = {24'h0, byte_sel};
      F3_HU:   data_c = {16'h0, half_sel};
      default: data_c = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with load/store unit: valid/ready request and
// response, 1-cycle registered read, fault detection and zero-fill after reset.
module data_mem_lsu
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);

  logic [31:0]      mem [DEPTH];

  logic [1:0]       state, state_d;
  logic [IDX_W-1:0] clr_idx, clr_idx_d;
  logic             req_ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0]      rsp_rdata_d;

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic [31:0]      rd_word, ld_data, wdata_rep, merged;
  logic [3:0]       mask;
  logic             range_flt, align_flt, f3_flt, fault;

  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wdata;

  assign word_idx = req_addr[2 +: IDX_W];
  assign lane     = req_addr[1:0];
  assign rd_word  = mem[word_idx];

  lsu_load_extend u_ext (
    .word   (rd_word),
    .funct3 (req_funct3),
    .lane   (lane),
    .data_c (ld_data)
  );

  // Fault classification of the presented request
  always_comb begin
    range_flt = (req_addr >= ADDR_LIMIT);
    align_flt = 1'b0;
    case (req_funct3[1:0])
      2'b01:   align_flt = lane[0];
      2'b10:   align_flt = (lane != 2'b00);
      default: align_flt = 1'b0;
    endcase
    if (req_we) f3_flt = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    else        f3_flt = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
    fault = range_flt | align_flt | f3_flt;
  end

  // Store lane merge: replicate the store data into every lane, then keep only masked lanes
  always_comb begin
    mask = lane_mask(req_funct3[1:0], lane);
    case (req_funct3[1:0])
      2'b00:   wdata_rep = {4{req_wdata[7:0]}};
      2'b01:   wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = wdata_rep[8*i +: 8];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    clr_idx_d   = clr_idx;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    mem_we      = 1'b0;
    mem_widx    = word_idx;
    mem_wdata   = merged;
    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = clr_idx;
        mem_wdata = 32'h0;
        clr_idx_d = clr_idx + IDX_W'(1);
        if (clr_idx == LAST_IDX) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_RESP;
          rsp_err_d   = fault;
          rsp_rdata_d = (fault || req_we) ? 32'h0 : ld_data;
          mem_we      = req_we && !fault;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      clr_idx   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      clr_idx   <= clr_idx_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  // Array has no reset; the CLEAR sweep provides the zero contents
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu (DEPTH=64): clear sweep, sub-word loads and
// stores, faults, backpressure and reset during a pending response.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  data_mem_lsu #(.DEPTH(64), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 200 && req_ready !== 1'b1; i++) @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Release reset and verify the 64-cycle clear window
  task automatic clear_sweep(input string tag);
    logic ok;
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (63) begin
      @(posedge clk); #1;
      if (req_ready !== 1'b0) ok = 1'b0;
    end
    check({tag, "_ready_low_63"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    check({tag, "_ready_at_64"}, 32'(req_ready), 32'd1);
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                     input string tag);
    @(negedge clk);
    wait_ready(tag);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rdata"}, rsp_rdata, exp_d);
    check({tag, "_err"},   32'(rsp_err), 32'(exp_e));
    @(posedge clk); #1;
    check({tag, "_done"},  32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic stable;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    clear_sweep("init");

    txn(1'b0, 3'b010, 32'hFC, 32'h0, 32'h0, 1'b0, "lw_fc_zero");
    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
    txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");

    txn(1'b1, 3'b000, 32'h05, 32'h00000080, 32'h0, 1'b0, "sb_05");
    txn(1'b0, 3'b000, 32'h05, 32'h0, 32'hFFFFFF80, 1'b0, "lb_05");
    txn(1'b0, 3'b100, 32'h05, 32'h0, 32'h00000080, 1'b0, "lbu_05");
    txn(1'b0, 3'b010, 32'h04, 32'h0, 32'h00008000, 1'b0, "lw_04");
    txn(1'b0, 3'b001, 32'h04, 32'h0, 32'hFFFF8000, 1'b0, "lh_04");
    txn(1'b0, 3'b101, 32'h04, 32'h0, 32'h00008000, 1'b0, "lhu_04");
    txn(1'b0, 3'b001, 32'h06, 32'h0, 32'h00000000, 1'b0, "lh_06");

    txn(1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1, "lw_02_mis");
    txn(1'b1, 3'b001, 32'h11, 32'h0000CAFE, 32'h0, 1'b1, "sh_11_mis");
    txn(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10_kept");
    txn(1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1, "lw_100_range");
    txn(1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, "ld_f3_011");
    txn(1'b1, 3'b100, 32'h00, 32'h55, 32'h0, 1'b1, "st_f3_100");
    txn(1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0, "sb_13");
    txn(1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 1'b0, "sh_12");
    txn(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, "lw_10_merge");

    // Backpressure: response must hold while rsp_ready is low
    rsp_ready = 1'b0;
    @(negedge clk);
    wait_ready("bp");
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_valid", 32'(rsp_valid), 32'd1);
    check("bp_rdata", rsp_rdata, 32'h1234BEEF);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234BEEF || rsp_err !== 1'b0 || req_ready !== 1'b0)
        stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_ready", 32'(req_ready), 32'd1);

    // Reset while a store response is pending
    rsp_ready = 1'b0;
    @(negedge clk);
    wait_ready("rr");
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rr_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_async_valid", 32'(rsp_valid), 32'd0);
    check("rr_async_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    clear_sweep("rr");
    txn(1'b0, 3'b010, 32'h00, 32'h0, 32'h0, 1'b0, "lw_00_cleared");
    txn(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0, "lw_10_cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
